reset_sequencer: RTL and testbench
==================================

# reset_sequencer

- Parametrised power-on and button reset generator: synchronises and optionally debounces an external button.
- Holds all downstream resets asserted for a programmable hold period, then releases up to `CHANNELS` reset outputs one after another at a fixed stagger.
- Sits at the top level between the board clock/button pins and the design's subsystems, so that clocking, memory and datapath blocks leave reset in a defined order.

## Interface
- `COUNT_WIDTH`, 23, hold counter width; hold period = 2^COUNT_WIDTH clock edges.
- `CHANNELS`, 4, number of reset outputs (≥1).
- `STAGGER`, 256, cycles between successive channel releases (≥1).
- `DEBOUNCE`, 16, consecutive stable cycles required to accept a button change (≥2, used only with debounce enabled).
- `Clk`  input  1  system clock.
- `nReset`  input  1  asynchronous, active-low reset of the block itself (one clock; reset asynchronous active-low).
- `Button`  input  1  external reset request, active-high, asynchronous to `Clk`.
- `Reset`  output  CHANNELS  per-channel active-high reset; bit 0 releases first.
- `Stage`  output  $clog2(CHANNELS+1)  number of channels currently released.
- `Ready`  output  1  high when all channels are released.

## Operation
- **Button path:**
  - Two-flop synchroniser produces `btn_s`.
  - Debounce filter (see Configuration) produces `btn_f`.
  - All flops clear on `nReset` low.
- **FSM states:** HOLD, STAG, DONE.
- **Async reset (`nReset` low):**
  - `Reset` = all ones, `Stage` = 0, `Ready` = 0.
  - Hold counter = 0, stagger counter = 0, state = HOLD.
- **`btn_f` high (any state, synchronous):** same values as async reset; takes priority over all transitions. Holding the button keeps the block in HOLD with hold counter 0.
- **HOLD:**
  - Hold counter increments each edge.
  - At the edge where it equals all ones: `Reset[0]` ← 0, `Stage` ← 1, stagger counter ← 0, state ← STAG.
  - If `CHANNELS` = 1, state ← DONE and `Ready` ← 1 at that edge instead.
- **STAG:**
  - Stagger counter increments each edge.
  - At the edge where it equals `STAGGER`-1: `Reset[Stage]` ← 0, `Stage` ← `Stage`+1, stagger counter ← 0.
  - If the new `Stage` = `CHANNELS`: state ← DONE and `Ready` ← 1 at the same edge.
- **DONE:** counters frozen; outputs stable until button or `nReset`.
- **Released channels** never re-assert individually; only a full restart re-asserts them.
- **Counters** never wrap: the hold counter stops at all ones, and the stagger counter is cleared on each release.

## Timing
- All outputs are registered; no combinational path from input to output.
- **Deassertion of `nReset`** is counted from the first rising edge after it goes high, with the button inactive:
  - `Reset[0]` falls at edge 2^COUNT_WIDTH.
  - `Reset[k]` falls at edge 2^COUNT_WIDTH + k·`STAGGER`.
  - `Ready` rises with the last release.
- **Button assertion latency to `Reset` all ones:**
  - Without debounce: 3 edges.
  - With debounce: 3 + `DEBOUNCE` edges.
- **Button release:** the restart count begins the edge after `btn_f` falls.
- **Mid-sequence button:** restarts from HOLD with hold counter 0. No partial state is retained.
- **Asynchronous `nReset`** overrides everything immediately, without waiting for a clock edge.

## Configuration
- **`RESET_SEQ_DEBOUNCE_EN` defined:**
  - A `$clog2(DEBOUNCE)`-bit counter runs while `btn_s` ≠ `btn_f` and clears when they match.
  - `btn_f` takes `btn_s` at the edge the counter reaches `DEBOUNCE`-1.
  - Glitches shorter than `DEBOUNCE` cycles are ignored.
- **Undefined:**
  - `btn_f` = `btn_s` with no debounce counter present.
  - Any synchronised pulse of 1 cycle or more restarts the sequence.

## Test plan
Bench parameters: `COUNT_WIDTH`=4, `CHANNELS`=3, `STAGGER`=4, `DEBOUNCE`=4.

- **Power-up:** `nReset` low 5 cycles then high, `Button`=0 -> `Reset`=3'b111 during reset; `Reset[0]` falls at edge 16, `Reset[1]` at 20, `Reset[2]` at 24; `Ready`=1 and `Stage`=3 at edge 24; stable to edge 100.
- **Mid-sequence button:** `Button` high 10 cycles starting at edge 21 (`Stage`=2) -> `Reset`=3'b111, `Stage`=0, `Ready`=0 at edge 24 (no debounce) or 28 (debounce); full sequence repeats, `Reset[0]` falls 16 edges after `btn_f` falls.
- **Glitch, debounce enabled:** 2-cycle `Button` pulse in DONE -> outputs unchanged (`Ready`=1, `Reset`=0). With `RESET_SEQ_DEBOUNCE_EN` undefined, the same pulse restarts the sequence.
- **Async reset mid-STAG:** `nReset` low between clock edges -> `Reset`=3'b111 and `Ready`=0 before the next rising edge; restart timing identical to power-up.
- **Held button:** `Button` high 40 cycles -> `Reset` stays 3'b111 and the hold counter stays 0 throughout; release timing counted from `btn_f` fall.
- **`CHANNELS`=1 build:** power-up -> `Reset[0]` falls and `Ready` rises together at edge 16; `Stage`=1.

Source files
------------

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - power-on/button reset sequencer with staggered per-channel release.
// Optional button debounce filter enabled by defining RESET_SEQ_DEBOUNCE_EN.
module reset_sequencer #(
   parameter int COUNT_WIDTH = 23,
   parameter int CHANNELS    = 4,
   parameter int STAGGER     = 256,
   parameter int DEBOUNCE    = 16
) (
   input  logic                               Clk,
   input  logic                               nReset,
   input  logic                               Button,
   output logic [CHANNELS-1:0]                Reset,
   output logic [$clog2(CHANNELS+1)-1:0]      Stage,
   output logic                               Ready
);

   localparam int SW = $clog2(CHANNELS+1);
   localparam int TW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

   typedef enum logic [1:0] {HOLD, STAG, DONE} state_t;

   state_t                 state, state_nx;
   logic [COUNT_WIDTH-1:0] hold_cnt, hold_nx;
   logic [TW-1:0]          stag_cnt, stag_nx;
   logic [CHANNELS-1:0]    rst_nx, rel_mask;
   logic [SW-1:0]          stage_nx;
   logic                   ready_nx;
   logic                   btn_m, btn_s, btn_f;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         btn_m <= 1'b0;
         btn_s <= 1'b0;
      end else begin
         btn_m <= Button;
         btn_s <= btn_m;
      end
   end

`ifdef RESET_SEQ_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE);
   logic [DW-1:0] db_cnt;

   // Counter only runs while the synchronised input disagrees with the filtered one.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         db_cnt <= '0;
         btn_f  <= 1'b0;
      end else if (btn_s == btn_f) begin
         db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE-1)) begin
         db_cnt <= '0;
         btn_f  <= btn_s;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end
`else
   logic unused_debounce;
   assign unused_debounce = (DEBOUNCE > 1);
   assign btn_f = btn_s;
`endif

   always_comb begin
      rel_mask = '0;
      for (int i = 0; i < CHANNELS; i++)
         rel_mask[i] = (Stage == SW'(i));
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state    <= HOLD;
         hold_cnt <= '0;
         stag_cnt <= '0;
         Reset    <= '1;
         Stage    <= '0;
         Ready    <= 1'b0;
      end else begin
         state    <= state_nx;
         hold_cnt <= hold_nx;
         stag_cnt <= stag_nx;
         Reset    <= rst_nx;
         Stage    <= stage_nx;
         Ready    <= ready_nx;
      end
   end

   always_comb begin
      state_nx = state;
      hold_nx  = hold_cnt;
      stag_nx  = stag_cnt;
      rst_nx   = Reset;
      stage_nx = Stage;
      ready_nx = Ready;
      if (btn_f) begin
         state_nx = HOLD;
         hold_nx  = '0;
         stag_nx  = '0;
         rst_nx   = '1;
         stage_nx = '0;
         ready_nx = 1'b0;
      end else begin
         case (state)
            HOLD: begin
               if (hold_cnt == '1) begin
                  rst_nx   = Reset & ~CHANNELS'(1);
                  stage_nx = SW'(1);
                  stag_nx  = '0;
                  if (CHANNELS == 1) begin
                     state_nx = DONE;
                     ready_nx = 1'b1;
                  end else begin
                     state_nx = STAG;
                  end
               end else begin
                  hold_nx = hold_cnt + 1'b1;
               end
            end
            STAG: begin
               if (stag_cnt == TW'(STAGGER-1)) begin
                  rst_nx   = Reset & ~rel_mask;
                  stage_nx = Stage + 1'b1;
                  stag_nx  = '0;
                  if (Stage == SW'(CHANNELS-1)) begin
                     state_nx = DONE;
                     ready_nx = 1'b1;
                  end
               end else begin
                  stag_nx = stag_cnt + 1'b1;
               end
            end
            DONE: ;
            default: state_nx = HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer (3-channel and 1-channel builds).
module tb_reset_sequencer;

   logic       clk, nreset, button;
   logic [2:0] rst3;
   logic [1:0] stage3;
   logic       ready3;
   logic [0:0] rst1;
   logic [0:0] stage1;
   logic       ready1;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;

   typedef struct {
      int         cyc;
      logic [2:0] rst;
      logic [1:0] stg;
      logic       rdy;
      bit         chk1;
      logic       r1;
      logic       s1;
      logic       rdy1;
      string      name;
   } exp_t;

   exp_t q[$];

   reset_sequencer #(.COUNT_WIDTH(4), .CHANNELS(3), .STAGGER(4), .DEBOUNCE(4)) dut (
      .Clk(clk), .nReset(nreset), .Button(button),
      .Reset(rst3), .Stage(stage3), .Ready(ready3)
   );

   reset_sequencer #(.COUNT_WIDTH(4), .CHANNELS(1), .STAGGER(4), .DEBOUNCE(4)) dut1 (
      .Clk(clk), .nReset(nreset), .Button(button),
      .Reset(rst1), .Stage(stage1), .Ready(ready1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic void ex(int c, logic [2:0] r, logic [1:0] s, logic rd, string nm);
      exp_t e;
      e.cyc = c; e.rst = r; e.stg = s; e.rdy = rd;
      e.chk1 = 1'b0; e.r1 = 1'b0; e.s1 = 1'b0; e.rdy1 = 1'b0; e.name = nm;
      q.push_back(e);
   endfunction

   function automatic void ex1(int c, logic [2:0] r, logic [1:0] s, logic rd,
                               logic r1, logic s1, logic rd1, string nm);
      exp_t e;
      e.cyc = c; e.rst = r; e.stg = s; e.rdy = rd;
      e.chk1 = 1'b1; e.r1 = r1; e.s1 = s1; e.rdy1 = rd1; e.name = nm;
      q.push_back(e);
   endfunction

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic restart(output int t);
      tick(1);
      nreset = 1'b0;
      tick(2);
      nreset = 1'b1;
      t = cyc;
   endtask

   // Monitor: compares sampled outputs on the falling edge against the queued expectation.
   initial begin
      exp_t e;
      bit   ok;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: sample at cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
         end
         if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            n_cmp++;
            ok = (rst3 == e.rst) && (stage3 == e.stg) && (ready3 == e.rdy);
            if (e.chk1)
               ok = ok && (rst1[0] == e.r1) && (stage1[0] == e.s1) && (ready1 == e.rdy1);
            if (!ok) begin
               n_bad++;
               $display("FAIL %s @%0d: got Reset=%b Stage=%0d Ready=%b [ch1 %b/%b/%b] expected Reset=%b Stage=%0d Ready=%b [ch1 %b/%b/%b chk=%0d]",
                        e.name, cyc, rst3, stage3, ready3, rst1, stage1, ready1,
                        e.rst, e.stg, e.rdy, e.r1, e.s1, e.rdy1, e.chk1);
            end
         end
      end
   end

   initial begin
      int t0, g, t1, t2, t3, h;
      nreset = 1'b0;
      button = 1'b0;

      // Power-up
      ex1(2, 3'b111, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, "in_reset");
      tick(5);
      nreset = 1'b1;
      t0 = cyc;
      ex1(t0+15, 3'b111, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, "pu_hold");
      ex1(t0+16, 3'b110, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, "pu_rel0");
      ex (t0+19, 3'b110, 2'd1, 1'b0, "pu_pre1");
      ex (t0+20, 3'b100, 2'd2, 1'b0, "pu_rel1");
      ex (t0+23, 3'b100, 2'd2, 1'b0, "pu_pre2");
      ex (t0+24, 3'b000, 2'd3, 1'b1, "pu_done");
      ex (t0+100, 3'b000, 2'd3, 1'b1, "pu_stable");
      tick(101);

      // 2-cycle glitch while DONE
      g = cyc;
`ifdef RESET_SEQ_DEBOUNCE_EN
      ex(g+3,  3'b000, 2'd3, 1'b1, "glitch_a");
      ex(g+10, 3'b000, 2'd3, 1'b1, "glitch_b");
      ex(g+28, 3'b000, 2'd3, 1'b1, "glitch_c");
`else
      ex(g+2,  3'b000, 2'd3, 1'b1, "glitch_pre");
      ex(g+3,  3'b111, 2'd0, 1'b0, "glitch_rst");
      ex(g+19, 3'b111, 2'd0, 1'b0, "glitch_hold");
      ex(g+20, 3'b110, 2'd1, 1'b0, "glitch_rel0");
      ex(g+28, 3'b000, 2'd3, 1'b1, "glitch_done");
`endif
      button = 1'b1;
      tick(2);
      button = 1'b0;
      tick(39);

      // Mid-sequence button, 10 cycles from edge 21
      restart(t1);
      ex(t1+21, 3'b100, 2'd2, 1'b0, "mid_stage2");
`ifdef RESET_SEQ_DEBOUNCE_EN
      ex(t1+24, 3'b000, 2'd3, 1'b1, "mid_done");
      ex(t1+27, 3'b000, 2'd3, 1'b1, "mid_pre");
      ex(t1+28, 3'b111, 2'd0, 1'b0, "mid_rst");
      ex(t1+52, 3'b111, 2'd0, 1'b0, "mid_hold");
      ex(t1+53, 3'b110, 2'd1, 1'b0, "mid_rel0");
      ex(t1+61, 3'b000, 2'd3, 1'b1, "mid_redone");
`else
      ex(t1+23, 3'b100, 2'd2, 1'b0, "mid_pre");
      ex(t1+24, 3'b111, 2'd0, 1'b0, "mid_rst");
      ex(t1+48, 3'b111, 2'd0, 1'b0, "mid_hold");
      ex(t1+49, 3'b110, 2'd1, 1'b0, "mid_rel0");
      ex(t1+57, 3'b000, 2'd3, 1'b1, "mid_redone");
`endif
      tick(21);
      button = 1'b1;
      tick(10);
      button = 1'b0;
      tick(39);

      // Asynchronous reset mid-STAG, checked before the next rising edge
      restart(t2);
      ex(t2+17, 3'b110, 2'd1, 1'b0, "async_pre");
      ex(t2+18, 3'b111, 2'd0, 1'b0, "async_now");
      tick(18);
      nreset = 1'b0;
      tick(2);
      nreset = 1'b1;
      t3 = cyc;
      ex1(t3+15, 3'b111, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, "async_hold");
      ex1(t3+16, 3'b110, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, "async_rel0");
      ex (t3+20, 3'b100, 2'd2, 1'b0, "async_rel1");
      ex (t3+24, 3'b000, 2'd3, 1'b1, "async_done");
      tick(30);

      // Held button, 40 cycles
      h = cyc;
`ifdef RESET_SEQ_DEBOUNCE_EN
      ex (h+6,  3'b000, 2'd3, 1'b1, "held_pre");
      ex (h+7,  3'b111, 2'd0, 1'b0, "held_rst");
      ex (h+30, 3'b111, 2'd0, 1'b0, "held_mid");
      ex1(h+61, 3'b111, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, "held_hold");
      ex1(h+62, 3'b110, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, "held_rel0");
      ex (h+70, 3'b000, 2'd3, 1'b1, "held_done");
`else
      ex (h+2,  3'b000, 2'd3, 1'b1, "held_pre");
      ex (h+3,  3'b111, 2'd0, 1'b0, "held_rst");
      ex (h+30, 3'b111, 2'd0, 1'b0, "held_mid");
      ex1(h+57, 3'b111, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, "held_hold");
      ex1(h+58, 3'b110, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, "held_rel0");
      ex (h+66, 3'b000, 2'd3, 1'b1, "held_done");
`endif
      button = 1'b1;
      tick(40);
      button = 1'b0;
      tick(80);

      @(negedge clk);
      #1;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover: %0d expectations unconsumed, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
